// File: rtl/multicycle_control_unit.sv
// Multicycle CPU controller: sequences IF/ID/EXE/MEM/WB over the shared
// single-cycle datapath, drives every control strobe from the current state
// and opcode, flags undefined opcodes and counts retired instructions.
module multicycle_control_unit #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opCode,
    input  logic             zero,
    output logic             PCWre,
    output logic             IRWre,
    output logic             InsMemRW,
    output logic             RegWre,
    output logic             RegOut,
    output logic             ALUSrcB,
    output logic [2:0]       ALUOp,
    output logic             ALUM2Reg,
    output logic             DataMemRW,
    output logic [1:0]       PCSrc,
    output logic             ExtSel,
    output logic [3:0]       state,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    localparam logic [3:0] S_IF     = 4'd0;
    localparam logic [3:0] S_ID     = 4'd1;
    localparam logic [3:0] S_EXE_AL = 4'd2;
    localparam logic [3:0] S_EXE_BR = 4'd3;
    localparam logic [3:0] S_EXE_LS = 4'd4;
    localparam logic [3:0] S_MEM    = 4'd5;
    localparam logic [3:0] S_WB_AL  = 4'd6;
    localparam logic [3:0] S_WB_LD  = 4'd7;
    localparam logic [3:0] S_HALT   = 4'd8;

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b000001;
    localparam logic [5:0] OP_ADDI = 6'b000010;
    localparam logic [5:0] OP_OR   = 6'b010000;
    localparam logic [5:0] OP_AND  = 6'b010001;
    localparam logic [5:0] OP_ORI  = 6'b010010;
    localparam logic [5:0] OP_SLT  = 6'b011000;
    localparam logic [5:0] OP_SW   = 6'b100110;
    localparam logic [5:0] OP_LW   = 6'b100111;
    localparam logic [5:0] OP_BEQ  = 6'b110000;
    localparam logic [5:0] OP_J    = 6'b111000;
    localparam logic [5:0] OP_HALT = 6'b111111;

    logic [3:0]       state_q;
    logic [3:0]       state_d;
    logic             illegal_q;
    logic [CNT_W-1:0] retired_q;
    logic             pc_step;
    logic             is_r, is_addi, is_ori, is_lw, is_sw, is_beq, is_j, is_halt, is_legal;
    logic [2:0]       alu_op;

    // Opcode classification and per-opcode ALU operation
    always_comb begin
        is_r    = 1'b0;
        is_addi = (opCode == OP_ADDI);
        is_ori  = (opCode == OP_ORI);
        is_lw   = (opCode == OP_LW);
        is_sw   = (opCode == OP_SW);
        is_beq  = (opCode == OP_BEQ);
        is_j    = (opCode == OP_J);
        is_halt = (opCode == OP_HALT);
        alu_op  = 3'b000;
        case (opCode)
            OP_ADD: is_r = 1'b1;
            OP_SUB: begin is_r = 1'b1; alu_op = 3'b001; end
            OP_OR:  begin is_r = 1'b1; alu_op = 3'b010; end
            OP_AND: begin is_r = 1'b1; alu_op = 3'b011; end
            OP_SLT: begin is_r = 1'b1; alu_op = 3'b100; end
            OP_ORI: alu_op = 3'b010;
            OP_BEQ: alu_op = 3'b001;
            default: ;
        endcase
        is_legal = is_r | is_addi | is_ori | is_lw | is_sw | is_beq | is_j | is_halt;
    end

    // Next-state selection; unreachable encodings fall back to IF
    always_comb begin
        state_d = S_IF;
        case (state_q)
            S_IF: state_d = S_ID;
            S_ID: begin
                if (is_halt)                 state_d = S_HALT;
                else if (is_beq)             state_d = S_EXE_BR;
                else if (is_lw | is_sw)      state_d = S_EXE_LS;
                else if (is_r | is_addi | is_ori) state_d = S_EXE_AL;
                else                         state_d = S_IF;
            end
            S_EXE_AL: state_d = S_WB_AL;
            S_EXE_BR: state_d = S_IF;
            S_EXE_LS: state_d = S_MEM;
            S_MEM:    state_d = is_lw ? S_WB_LD : S_IF;
            S_WB_AL:  state_d = S_IF;
            S_WB_LD:  state_d = S_IF;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IF;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IF;
        else        state_q <= state_d;
    end

    // Sticky undefined-opcode flag, raised while decoding
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                          illegal_q <= 1'b0;
        else if (state_q == S_ID && !is_legal) illegal_q <= 1'b1;
    end

    // Retired-instruction counter, wraps freely
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)       retired_q <= '0;
        else if (pc_step) retired_q <= retired_q + CNT_W'(1);
    end

    // Control strobes decoded from state and opcode; write enables gated by reset
    always_comb begin
        pc_step   = ((state_q == S_ID) && (is_j || !is_legal)) ||
                    (state_q == S_EXE_BR) ||
                    ((state_q == S_MEM) && is_sw) ||
                    (state_q == S_WB_AL) || (state_q == S_WB_LD);
        PCWre     = reset & pc_step;
        IRWre     = reset & (state_q == S_IF);
        InsMemRW  = (state_q == S_IF);
        RegWre    = reset & ((state_q == S_WB_AL) || (state_q == S_WB_LD));
        DataMemRW = reset & (state_q == S_MEM) & is_sw;
        RegOut    = is_r;
        ALUSrcB   = is_addi | is_ori | is_lw | is_sw;
        ALUOp     = alu_op;
        ALUM2Reg  = (state_q == S_WB_LD);
        ExtSel    = ~is_ori;
        PCSrc     = 2'b00;
        if (state_q == S_ID && is_j)            PCSrc = 2'b10;
        else if (state_q == S_EXE_BR && zero)   PCSrc = 2'b01;
        state     = state_q;
        halted    = (state_q == S_HALT);
        illegal   = illegal_q;
        retired   = retired_q;
    end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- State-machine controller that sequences the existing single-cycle datapath (PC, instruction memory, register block, ALU, data memory, sign/zero extender) as a multicycle CPU.
- Adds an instruction register enable (IRWre) and splits each instruction into IF/ID/EXE/MEM/WB states.
- Generates every datapath control strobe per state and keeps a retired-instruction counter.
- Replaces the combinational ControlUnit at CPU top level.

Parameters:
CNT_W, 32, width of retired-instruction counter

Ports:
clk  input  1  system clock, all state changes on rising edge
reset  input  1  asynchronous, active-low reset
opCode  input  6  opcode from instruction register, stable from ID onward
zero  input  1  ALU zero flag, combinational from ALU
PCWre  output  1  PC write enable, one-cycle pulse on last state of each instruction
IRWre  output  1  instruction register load enable
InsMemRW  output  1  instruction memory read (1 = read)
RegWre  output  1  register file write enable
RegOut  output  1  write-register select: 1 = rd, 0 = rt
ALUSrcB  output  1  ALU B source: 1 = extended immediate, 0 = rt data
ALUOp  output  3  000 add, 001 sub, 010 or, 011 and, 100 slt (signed)
ALUM2Reg  output  1  write-back source: 1 = data memory, 0 = ALU
DataMemRW  output  1  data memory write (1 = write, 0 = read)
PCSrc  output  2  00 PC+4, 01 PC+4+(ext<<2), 10 jump target
ExtSel  output  1  1 = sign extend, 0 = zero extend
state  output  4  current state encoding, for debug/bench
halted  output  1  high while in HALT
illegal  output  1  sticky, set when an undefined opcode is decoded
retired  output  CNT_W  count of PCWre pulses since reset

Behaviour:
- State encoding: IF=0, ID=1, EXE_AL=2, EXE_BR=3, EXE_LS=4, MEM=5, WB_AL=6, WB_LD=7, HALT=8. Values 9-15 are unreachable; if entered, next state is IF.
- Opcodes: add 000000, sub 000001, addi 000010, or 010000, and 010001, ori 010010, slt 011000, sw 100110, lw 100111, beq 110000, j 111000, halt 111111. All others are illegal.
- Transitions:
  - IF->ID always.
  - ID: j->IF; halt->HALT; illegal->IF; beq->EXE_BR; lw/sw->EXE_LS; R-type/addi/ori->EXE_AL.
  - EXE_AL->WB_AL->IF.
  - EXE_BR->IF.
  - EXE_LS->MEM.
  - MEM: sw->IF; lw->WB_LD.
  - WB_LD->IF.
  - HALT->HALT until reset.
- Latencies: j 2 cycles, beq 3, R-type/addi/ori 4, sw 4, lw 5.
- All outputs are combinational decode of the state register and opCode. Register-to-output has no extra latency.
- IRWre=1 and InsMemRW=1 in IF only.
- PCWre=1 for exactly one cycle, in the final state of each instruction:
  - ID for j and illegal;
  - EXE_BR;
  - MEM for sw;
  - WB_AL;
  - WB_LD.
- PCWre=0 in HALT.
- PCSrc: 10 in ID for j; 01 in EXE_BR when zero=1; 00 otherwise.
- beq samples zero combinationally in EXE_BR; ALUOp=001 there.
- RegWre=1 only in WB_AL and WB_LD.
  - RegOut=1 for R-type, 0 for addi/ori/lw.
  - ALUM2Reg=1 only in WB_LD.
- DataMemRW=1 only in MEM for sw.
- ALUSrcB=1 for addi, ori, lw, sw, in all states of those instructions.
- ALUOp is held constant per opcode across EXE and WB: addi/lw/sw use add; ori uses or.
- ExtSel=0 only for ori, else 1.
- Write enables (PCWre, IRWre, RegWre, DataMemRW) are 0 in every state not listed above.
- retired increments by 1 on every clock edge where PCWre=1. It wraps modulo 2^CNT_W with no saturation.
- illegal is set in ID on an undefined opcode and stays set until reset.
- Reset (reset=0, asynchronous, any time including mid-instruction):
  - state=IF, retired=0, illegal=0.
  - While reset is low: PCWre, IRWre, RegWre, DataMemRW are forced 0.
- Reset release: first rising edge after reset deassertion performs IF (IRWre=1).

Test Plan:
- reset low during WB_LD of lw -> state=0, RegWre=0 and retired=0 immediately (asynchronous); after release, IF with IRWre=1 on the next cycle.
- add (000000) from reset -> state sequence 0,1,2,6,0; RegWre=1, RegOut=1, ALUOp=000 only in state 6; PCWre pulses once; retired=1.
- lw then sw -> lw states 0,1,4,5,7 with ALUM2Reg=1 and RegOut=0 in 7. sw states 0,1,4,5 with DataMemRW=1 only in 5. ExtSel=1, ALUSrcB=1 throughout; retired=2.
- beq with zero=1 then beq with zero=0 -> PCSrc=01 then 00 in state 3, PCWre=1 in state 3 both times, ALUOp=001.
- ori -> ExtSel=0, ALUOp=010, ALUSrcB=1; j -> state 1 has PCSrc=10 and PCWre=1, then returns to 0.
- opcode 101010 -> illegal=1, PCWre=1/PCSrc=00 in ID, execution continues. Then halt 111111 -> state=8, halted=1, PCWre=0 for 10+ cycles, retired frozen.
